// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART TX channel.
// The master modport is the arbiter side; the slave modport is the environment side.
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC = 4
);
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  src_data, src_valid, src_last, out_ready,
    output src_ready, out_data, out_valid
  );

  modport slave (
    output src_data, src_valid, src_last, out_ready,
    input  src_ready, out_data, out_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX channel among NUM_SRC byte streams.
// Optional source tag byte before each packet when UART_ARB_SRC_TAG_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_SRC       = 4,
  parameter int MAX_PKT_BYTES = 256,
  parameter int GAP_CYCLES    = 17360
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_tx_arbiter_if.master  bus,
  output logic [2:0]         o_grant_id,
  output logic               o_busy
);

  localparam int BCW = $clog2(MAX_PKT_BYTES + 1);
  localparam int GCW = $clog2(GAP_CYCLES);
  localparam logic [BCW-1:0] MAX_CNT  = BCW'(MAX_PKT_BYTES);
  localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP_CYCLES - 1);
  localparam logic [2:0]     LAST_SRC = 3'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef UART_ARB_SRC_TAG_EN
    ST_TAG  = 2'd1,
`endif
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [2:0]       r_rr_ptr;
  logic [2:0]       r_grant_id;
  logic [BCW-1:0]   r_byte_cnt;
  logic [GCW-1:0]   r_gap_cnt;

  logic [7:0]       w_valid_pad;
  logic [7:0]       w_last_pad;
  logic [63:0]      w_data_pad;
  logic             w_gnt_valid;
  logic             w_gnt_last;
  logic [7:0]       w_gnt_data;
  logic             w_take;
  logic [BCW-1:0]   w_cnt_inc;
  logic             w_pkt_end;
  logic             w_hit;
  logic [2:0]       w_pick;
  logic [2:0]       w_idx;
  logic [7:0]       w_out_data;
  logic             w_out_valid;
  logic [7:0]       w_ready_pad;

  // Pad the per-source vectors to 8 lanes so a 3-bit grant index selects cleanly.
  always_comb begin
    w_valid_pad = 8'd0;
    w_last_pad  = 8'd0;
    w_data_pad  = 64'd0;
    w_valid_pad[NUM_SRC-1:0]   = bus.src_valid;
    w_last_pad[NUM_SRC-1:0]    = bus.src_last;
    w_data_pad[8*NUM_SRC-1:0]  = bus.src_data;
  end

  assign w_gnt_valid = w_valid_pad[r_grant_id];
  assign w_gnt_last  = w_last_pad[r_grant_id];
  assign w_gnt_data  = w_data_pad[{r_grant_id, 3'b000} +: 8];
  assign w_take      = (r_state == ST_SEND) & w_gnt_valid & bus.out_ready;
  assign w_cnt_inc   = r_byte_cnt + BCW'(1);
  assign w_pkt_end   = w_gnt_last | (w_cnt_inc == MAX_CNT);

  // Round-robin scan: first requester after the last granted source wins.
  always_comb begin
    w_hit  = 1'b0;
    w_pick = 3'd0;
    w_idx  = 3'd0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_idx = 3'((int'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_hit && w_valid_pad[w_idx]) begin
        w_pick = w_idx;
        w_hit  = 1'b1;
      end else begin
        w_pick = w_pick;
      end
    end
  end

  // Output mux; src_ready is zero-latency because the channel samples as it pulses ready.
  always_comb begin
    w_out_data  = 8'd0;
    w_out_valid = 1'b0;
    w_ready_pad = 8'd0;
    case (r_state)
      ST_SEND: begin
        w_out_data              = w_gnt_data;
        w_out_valid             = w_gnt_valid;
        w_ready_pad[r_grant_id] = bus.out_ready & w_gnt_valid;
      end
`ifdef UART_ARB_SRC_TAG_EN
      ST_TAG: begin
        w_out_data  = {5'b10100, r_grant_id};
        w_out_valid = 1'b1;
      end
`endif
      default: begin
        w_out_data  = 8'd0;
        w_out_valid = 1'b0;
      end
    endcase
  end

  assign bus.out_data  = w_out_data;
  assign bus.out_valid = w_out_valid;
  assign bus.src_ready = w_ready_pad[NUM_SRC-1:0];
  assign o_grant_id    = r_grant_id;
  assign o_busy        = (r_state != ST_IDLE);

  // Packet FSM: grant, forward one packet, then hold the channel idle for the gap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= LAST_SRC;
      r_grant_id <= 3'd0;
      r_byte_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            r_grant_id <= w_pick;
            r_byte_cnt <= '0;
`ifdef UART_ARB_SRC_TAG_EN
            r_state    <= ST_TAG;
`else
            r_state    <= ST_SEND;
`endif
          end
        end
`ifdef UART_ARB_SRC_TAG_EN
        ST_TAG: begin
          if (bus.out_ready) begin
            r_state <= ST_SEND;
          end
        end
`endif
        ST_SEND: begin
          // An empty granted source simply stalls here; the grant is kept.
          if (w_take) begin
            r_byte_cnt <= w_cnt_inc;
            if (w_pkt_end) begin
              r_rr_ptr  <= r_grant_id;
              r_gap_cnt <= GAP_LOAD;
              r_state   <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GCW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed sequences, an arbitration
// table and randomized packets scored against a queue-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NUM_SRC = 4;
  localparam int MAX_PKT = 256;
  localparam int GAP     = 20;
`ifdef UART_ARB_SRC_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] grant_id;
  logic       busy;

  uart_tx_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

  uart_tx_arbiter #(
    .NUM_SRC      (NUM_SRC),
    .MAX_PKT_BYTES(MAX_PKT),
    .GAP_CYCLES   (GAP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .bus        (bus),
    .o_grant_id (grant_id),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tag;
    logic       last;
    logic [2:0] g;
    logic [7:0] data;
  } exp_t;

  typedef struct packed {
    logic [3:0] mask;
    logic [2:0] g;
  } vec_t;

  logic [8:0]         src_q [NUM_SRC][$];
  exp_t               exp_q [$];
  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] pop_mask;
  int                 rdy_pct;
  bit                 gap_chk;
  bit                 gap_watch;
  int                 gap_low;
  int                 n_checks;
  int                 n_errors;
  vec_t               vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pop_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    pop_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      bus.src_valid[i]       = en[i] && (src_q[i].size() > 0);
      bus.src_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
      bus.src_last[i]        = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
    end
    bus.out_ready = (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  task automatic monitor();
    exp_t        e;
    logic [31:0] exp_rdy;
    if (gap_watch) begin
      if (!bus.out_valid) gap_low++;
      else begin
        if (gap_chk) chk("gap_len", gap_low, GAP + 1);
        gap_watch = 1'b0;
      end
    end
    pop_mask = bus.src_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL extra_byte: got 0x%0h from grant %0d with none expected (t=%0t)",
                 bus.out_data, grant_id, $time);
      end else begin
        e = exp_q.pop_front();
        exp_rdy = e.tag ? 32'd0 : (32'd1 << e.g);
        chk("out_data", bus.out_data, e.data);
        chk("grant_id", grant_id, e.g);
        chk("src_ready", bus.src_ready, exp_rdy);
        if (e.last) begin
          gap_watch = 1'b1;
          gap_low   = 0;
        end
      end
    end else begin
      chk("src_ready_no_take", bus.src_ready, 32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    monitor();
  endtask

  task automatic run_until_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    chk("idle_timeout", busy, 32'd0);
  endtask

  task automatic push_exp(input bit first, input logic [2:0] g, input logic [7:0] d, input bit last);
    if (first && TAG_EN) exp_q.push_back({1'b1, 1'b0, g, 5'b10100, g});
    exp_q.push_back({1'b0, last, g, d});
  endtask

  // Packet-level reference: round-robin over non-empty streams, cut at last or MAX_PKT bytes.
  task automatic build_expected(input int start_ptr);
    logic [8:0] mq [NUM_SRC][$];
    logic [8:0] b;
    int ptr, g, n, idx;
    bit done;
    for (int i = 0; i < NUM_SRC; i++) mq[i] = src_q[i];
    ptr = start_ptr;
    forever begin
      g = -1;
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = (ptr + k) % NUM_SRC;
        if (g < 0 && mq[idx].size() > 0) g = idx;
      end
      if (g < 0) break;
      n = 0;
      done = 1'b0;
      while (!done && mq[g].size() > 0) begin
        b = mq[g].pop_front();
        n++;
        done = b[8] || (n == MAX_PKT);
        push_exp(n == 1, 3'(g), b[7:0], done);
      end
      if (!done) break;
      ptr = g;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_q.delete();
    pop_mask  = '0;
    gap_watch = 1'b0;
    gap_low   = 0;
    rst       = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    en  = '1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_src_ready", bus.src_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_grant_id", grant_id, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rdy_pct  = 100;
    gap_chk  = 1'b0;
    en       = '0;
    bus.src_valid = '0;
    bus.src_data  = '0;
    bus.src_last  = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{mask: 4'b1111, g: 3'd0};
    vecs[1] = '{mask: 4'b1111, g: 3'd1};
    vecs[2] = '{mask: 4'b1001, g: 3'd3};
    vecs[3] = '{mask: 4'b0110, g: 3'd1};
    vecs[4] = '{mask: 4'b0001, g: 3'd0};
    vecs[5] = '{mask: 4'b0001, g: 3'd0};
    vecs[6] = '{mask: 4'b1100, g: 3'd2};
    vecs[7] = '{mask: 4'b0011, g: 3'd0};
    vecs[8] = '{mask: 4'b1000, g: 3'd3};
    vecs[9] = '{mask: 4'b0100, g: 3'd2};

    // Reset values, then a 3-byte packet from source 0 and the idle gap behind it.
    do_reset();
    check_reset_outputs();
    src_q[0].push_back({1'b0, 8'h11});
    src_q[0].push_back({1'b0, 8'h22});
    src_q[0].push_back({1'b1, 8'h33});
    push_exp(1'b1, 3'd0, 8'h11, 1'b0);
    push_exp(1'b0, 3'd0, 8'h22, 1'b0);
    push_exp(1'b0, 3'd0, 8'h33, 1'b1);
    run_until_empty(50);
    for (int k = 0; k < GAP; k++) begin
      cycle();
      chk("gap_out_valid", bus.out_valid, 32'd0);
      chk("gap_busy", busy, 32'd1);
    end
    cycle();
    chk("gap_done_idle", busy, 32'd0);

    // Four sources with 2-byte packets: grants 0,1,2,3,0 and no interleaving.
    do_reset();
    gap_chk = 1'b1;
    src_q[0].push_back({1'b0, 8'h00});
    src_q[0].push_back({1'b1, 8'h01});
    src_q[0].push_back({1'b0, 8'h02});
    src_q[0].push_back({1'b1, 8'h03});
    for (int i = 1; i < NUM_SRC; i++) begin
      src_q[i].push_back({1'b0, 8'(16 * i)});
      src_q[i].push_back({1'b1, 8'(16 * i + 1)});
    end
    build_expected(NUM_SRC - 1);
    run_until_empty(400);

    // Arbitration table: one-byte packets from the masked sources, one grant per vector.
    do_reset();
    gap_chk = 1'b0;
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        en[i] = vecs[v].mask[i];
        if (vecs[v].mask[i] && src_q[i].size() == 0) src_q[i].push_back({1'b1, 8'(8'h50 + i)});
      end
      push_exp(1'b1, vecs[v].g, 8'h50 + 8'(vecs[v].g), 1'b1);
      run_until_empty(100);
      en = '0;
      wait_idle(100);
    end

    // 300-byte stream from source 2: forced cut after 256 bytes, then the remaining 44.
    do_reset();
    gap_chk = 1'b1;
    for (int b = 0; b < 300; b++) src_q[2].push_back({b == 299, 8'(b)});
    build_expected(NUM_SRC - 1);
    run_until_empty(1000);

    // Source 1 runs dry after 2 of 5 bytes: grant is held, then the rest follows.
    do_reset();
    gap_chk = 1'b0;
    src_q[1].push_back({1'b0, 8'hE1});
    src_q[1].push_back({1'b0, 8'hE2});
    push_exp(1'b1, 3'd1, 8'hE1, 1'b0);
    push_exp(1'b0, 3'd1, 8'hE2, 1'b0);
    run_until_empty(50);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("hold_out_valid", bus.out_valid, 32'd0);
      chk("hold_busy", busy, 32'd1);
      chk("hold_grant", grant_id, 32'd1);
    end
    src_q[1].push_back({1'b0, 8'hE3});
    src_q[1].push_back({1'b0, 8'hE4});
    src_q[1].push_back({1'b1, 8'hE5});
    push_exp(1'b0, 3'd1, 8'hE3, 1'b0);
    push_exp(1'b0, 3'd1, 8'hE4, 1'b0);
    push_exp(1'b0, 3'd1, 8'hE5, 1'b1);
    run_until_empty(50);

    // Reset while byte 2 of a source-2 packet is on offer; source 0 wins afterwards.
    do_reset();
    gap_chk = 1'b1;
    src_q[2].push_back({1'b0, 8'hC1});
    src_q[2].push_back({1'b0, 8'hC2});
    src_q[2].push_back({1'b0, 8'hC3});
    src_q[2].push_back({1'b1, 8'hC4});
    push_exp(1'b1, 3'd2, 8'hC1, 1'b0);
    run_until_empty(50);
    rdy_pct = 0;
    cycle();
    chk("mid_byte2_shown", bus.out_data, 32'hC2);
    src_q[0].push_back({1'b1, 8'h0A});
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_reset_outputs();
    push_exp(1'b1, 3'd0, 8'h0A, 1'b1);
    push_exp(1'b1, 3'd2, 8'hC2, 1'b0);
    push_exp(1'b0, 3'd2, 8'hC3, 1'b0);
    push_exp(1'b0, 3'd2, 8'hC4, 1'b1);
    rdy_pct = 70;
    run_until_empty(300);

`ifdef UART_ARB_SRC_TAG_EN
    // Tag byte for source 3 precedes its data byte.
    do_reset();
    rdy_pct = 100;
    src_q[3].push_back({1'b1, 8'hAB});
    exp_q.push_back({1'b1, 1'b0, 3'd3, 8'hA3});
    exp_q.push_back({1'b0, 1'b1, 3'd3, 8'hAB});
    run_until_empty(50);
`endif

    // Randomized packets on all sources with a throttled channel.
    do_reset();
    gap_chk = 1'b1;
    rdy_pct = 70;
    for (int i = 0; i < NUM_SRC; i++) begin
      int npk, len;
      npk = int'($urandom_range(0, 3));
      for (int p = 0; p < npk; p++) begin
        len = int'($urandom_range(1, 8));
        for (int b = 0; b < len; b++) src_q[i].push_back({b == len - 1, 8'($urandom)});
      end
    end
    build_expected(NUM_SRC - 1);
    run_until_empty(4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
